// File: rtl/dac_event_ttl_gen.sv
`default_nettype none
// ============================================================================
// Module : dac_event_ttl_gen
// Brief  : Turns DAC threshold/window flag rising edges into width-programmable
//          TTL pulses with refractory hold-off and a saturating event counter.
//          Optional macro DAC_EVENT_TIMESTAMP_EN adds event timestamp capture.
// Rev    : 1.0 - initial release
// ============================================================================
module dac_event_ttl_gen #(
    parameter int unsigned SAMPLE_STATE   = 170,
    parameter int unsigned SAMPLE_CHANNEL = 0
) (
    input  logic        dataclk,
    input  logic        reset_n,
    input  logic [31:0] main_state,
    input  logic [5:0]  channel,
    input  logic        DAC_thrsh_out,
    input  logic        DAC_fsm_inwin_out,
    input  logic        event_en,
    input  logic        event_use_window,
    input  logic [15:0] pulse_width,
    input  logic [15:0] refractory,
    input  logic        event_count_clr,
    output logic        event_ttl,
    output logic        event_strobe,
    output logic        event_busy,
    output logic [15:0] event_count
`ifdef DAC_EVENT_TIMESTAMP_EN
    ,
    input  logic [31:0] timestamp,
    output logic [31:0] event_timestamp
`endif
);

    localparam logic [31:0] c_sample_state   = 32'(SAMPLE_STATE);
    localparam logic [5:0]  c_sample_channel = 6'(SAMPLE_CHANNEL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        REFRACT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] refr_q, refr_d;
    logic [15:0] count_q, count_d;
    logic        ttl_q, ttl_d;
    logic        stb_q, stb_d;
    logic        cond_prev_q, cond_prev_d;

    logic w_strobe;
    logic w_cond;
    logic w_rise;
    logic w_accept;

    assign w_strobe = (main_state == c_sample_state) && (channel == c_sample_channel);
    assign w_cond   = event_use_window ? DAC_fsm_inwin_out : DAC_thrsh_out;
    assign w_rise   = w_strobe && w_cond && !cond_prev_q;
    assign w_accept = (state_q == IDLE) && w_rise && event_en;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        refr_d      = refr_q;
        ttl_d       = ttl_q;
        stb_d       = 1'b0;
        cond_prev_d = w_strobe ? w_cond : cond_prev_q;

        if (!event_en) begin
            state_d = IDLE;
            ttl_d   = 1'b0;
            cnt_d   = 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        state_d = PULSE;
                        ttl_d   = 1'b1;
                        stb_d   = 1'b1;
                        cnt_d   = (pulse_width == 16'd0) ? 16'd0 : pulse_width - 16'd1;
                        refr_d  = refractory;
                    end
                end
                PULSE: begin
                    if (w_strobe) begin
                        if (cnt_q == 16'd0) begin
                            ttl_d = 1'b0;
                            if (refr_q != 16'd0) begin
                                state_d = REFRACT;
                                cnt_d   = refr_q - 16'd1;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q - 16'd1;
                        end
                    end
                end
                REFRACT: begin
                    // Rises are deliberately ignored here, even on the exiting strobe.
                    if (w_strobe) begin
                        if (cnt_q == 16'd0) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - 16'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    ttl_d   = 1'b0;
                    cnt_d   = 16'd0;
                end
            endcase
        end

        count_d = count_q;
        if (event_count_clr) begin
            count_d = w_accept ? 16'd1 : 16'd0;
        end else if (w_accept && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge dataclk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            refr_q      <= 16'd0;
            count_q     <= 16'd0;
            ttl_q       <= 1'b0;
            stb_q       <= 1'b0;
            cond_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            refr_q      <= refr_d;
            count_q     <= count_d;
            ttl_q       <= ttl_d;
            stb_q       <= stb_d;
            cond_prev_q <= cond_prev_d;
        end
    end

    assign event_ttl    = ttl_q;
    assign event_strobe = stb_q;
    assign event_busy   = (state_q != IDLE);
    assign event_count  = count_q;

`ifdef DAC_EVENT_TIMESTAMP_EN
    logic [31:0] ts_q;

    always_ff @(posedge dataclk) begin
        if (!reset_n) begin
            ts_q <= 32'd0;
        end else if (w_accept) begin
            ts_q <= timestamp;
        end
    end

    assign event_timestamp = ts_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dac_event_ttl_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_dac_event_ttl_gen
// Brief  : Directed scoreboard bench for dac_event_ttl_gen (4 dataclk per frame).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_dac_event_ttl_gen;

    logic        dataclk = 1'b0;
    logic        reset_n;
    logic [31:0] main_state;
    logic [5:0]  channel;
    logic        DAC_thrsh_out;
    logic        DAC_fsm_inwin_out;
    logic        event_en;
    logic        event_use_window;
    logic [15:0] pulse_width;
    logic [15:0] refractory;
    logic        event_count_clr;
    logic        event_ttl;
    logic        event_strobe;
    logic        event_busy;
    logic [15:0] event_count;
`ifdef DAC_EVENT_TIMESTAMP_EN
    logic [31:0] timestamp;
    logic [31:0] event_timestamp;
    logic [31:0] exp_ts;
`endif

    int checks = 0;
    int errors = 0;
    int frame_no = 0;

    typedef struct packed {
        logic        ttl;
        logic        stb;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    always #5 dataclk = ~dataclk;

    dac_event_ttl_gen #(
        .SAMPLE_STATE   (170),
        .SAMPLE_CHANNEL (0)
    ) dut (
        .dataclk           (dataclk),
        .reset_n           (reset_n),
        .main_state        (main_state),
        .channel           (channel),
        .DAC_thrsh_out     (DAC_thrsh_out),
        .DAC_fsm_inwin_out (DAC_fsm_inwin_out),
        .event_en          (event_en),
        .event_use_window  (event_use_window),
        .pulse_width       (pulse_width),
        .refractory        (refractory),
        .event_count_clr   (event_count_clr),
        .event_ttl         (event_ttl),
        .event_strobe      (event_strobe),
        .event_busy        (event_busy),
        .event_count       (event_count)
`ifdef DAC_EVENT_TIMESTAMP_EN
        ,
        .timestamp         (timestamp),
        .event_timestamp   (event_timestamp)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s frame=%0d observed=%0h expected=%0h", tag, frame_no, obs, exp);
        end
    endtask

    // One sample frame: strobe cycle first, then three non-strobe cycles.
    task automatic frame(input logic thr, input logic win, input logic en, input logic clr,
                         input logic e_ttl, input logic e_stb, input logic e_busy,
                         input logic [15:0] e_cnt);
        exp_t e;
        e = '{ttl: e_ttl, stb: e_stb, busy: e_busy, cnt: e_cnt};
        sb.push_back(e);
        main_state        = 32'd170;
        channel           = 6'd0;
        DAC_thrsh_out     = thr;
        DAC_fsm_inwin_out = win;
        event_en          = en;
        event_count_clr   = clr;
`ifdef DAC_EVENT_TIMESTAMP_EN
        timestamp = 32'(frame_no);
        if (e_stb) exp_ts = 32'(frame_no);
`endif
        @(posedge dataclk);
        #1;
        e = sb.pop_front();
        check("ttl",   {31'd0, event_ttl},    {31'd0, e.ttl});
        check("stb",   {31'd0, event_strobe}, {31'd0, e.stb});
        check("busy",  {31'd0, event_busy},   {31'd0, e.busy});
        check("count", {16'd0, event_count},  {16'd0, e.cnt});
`ifdef DAC_EVENT_TIMESTAMP_EN
        check("ts", event_timestamp, exp_ts);
`endif
        event_count_clr = 1'b0;
        channel         = 6'd1;
        @(posedge dataclk);
        #1;
        check("stb_low", {31'd0, event_strobe}, 32'd0);
        channel = 6'd2;
        @(posedge dataclk);
        #1;
        main_state = 32'd171;
        channel    = 6'd0;
        @(posedge dataclk);
        #1;
        frame_no++;
    endtask

    initial begin
        reset_n           = 1'b0;
        main_state        = 32'd0;
        channel           = 6'd0;
        DAC_thrsh_out     = 1'b0;
        DAC_fsm_inwin_out = 1'b0;
        event_en          = 1'b1;
        event_use_window  = 1'b0;
        pulse_width       = 16'd3;
        refractory        = 16'd0;
        event_count_clr   = 1'b0;
`ifdef DAC_EVENT_TIMESTAMP_EN
        timestamp = 32'd0;
        exp_ts    = 32'd0;
`endif
        repeat (2) @(posedge dataclk);
        #1;
        check("rst_ttl",   {31'd0, event_ttl},    32'd0);
        check("rst_stb",   {31'd0, event_strobe}, 32'd0);
        check("rst_busy",  {31'd0, event_busy},   32'd0);
        check("rst_count", {16'd0, event_count},  32'd0);
        reset_n = 1'b1;

        // 1: rise in frame 5, pulse_width=3, refractory=0
        for (int i = 0; i < 5; i++) frame(0, 0, 1, 0, 0, 0, 0, 16'd0);
        frame(1, 0, 1, 0, 1, 1, 1, 16'd1);
        frame(1, 0, 1, 0, 1, 0, 1, 16'd1);
        frame(1, 0, 1, 0, 1, 0, 1, 16'd1);
        frame(1, 0, 1, 0, 0, 0, 0, 16'd1);
        frame(0, 0, 1, 0, 0, 0, 0, 16'd1);

        // 3: flag held high 20 frames, pulse_width=1 -> a single event
        pulse_width = 16'd1;
        frame(1, 0, 1, 0, 1, 1, 1, 16'd2);
        for (int i = 0; i < 19; i++) frame(1, 0, 1, 0, 0, 0, 0, 16'd2);
        frame(0, 0, 1, 0, 0, 0, 0, 16'd2);

        // 2: toggling flag, pulse_width=2, refractory=4 -> one event per 8 frames
        pulse_width = 16'd2;
        refractory  = 16'd4;
        for (int i = 0; i < 16; i++) begin
            frame((i % 2) == 0, 0, 1, 0,
                  (i % 8) < 2, (i % 8) == 0, (i % 8) < 6,
                  (i < 8) ? 16'd3 : 16'd4);
        end

        // 4: window mode ignores the threshold flag
        pulse_width      = 16'd1;
        refractory       = 16'd0;
        event_use_window = 1'b1;
        frame(1, 0, 1, 0, 0, 0, 0, 16'd4);
        frame(1, 0, 1, 0, 0, 0, 0, 16'd4);
        frame(1, 1, 1, 0, 1, 1, 1, 16'd5);
        frame(1, 1, 1, 0, 0, 0, 0, 16'd5);
        frame(0, 0, 1, 0, 0, 0, 0, 16'd5);
        event_use_window = 1'b0;

        // 5: saturation and clear
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        frame(1, 0, 1, 0, 1, 1, 1, 16'hFFFF);
        frame(0, 0, 1, 0, 0, 0, 0, 16'hFFFF);
        frame(1, 0, 1, 0, 1, 1, 1, 16'hFFFF);
        frame(0, 0, 1, 0, 0, 0, 0, 16'hFFFF);
        frame(1, 0, 1, 1, 1, 1, 1, 16'd1);
        frame(0, 0, 1, 0, 0, 0, 0, 16'd1);
        frame(0, 0, 1, 1, 0, 0, 0, 16'd0);

        // 6: disable mid-pulse, then mid-event parameter change, then reset mid-refractory
        pulse_width = 16'd5;
        refractory  = 16'd3;
        frame(1, 0, 1, 0, 1, 1, 1, 16'd1);
        frame(1, 0, 1, 0, 1, 0, 1, 16'd1);
        frame(1, 0, 0, 0, 0, 0, 0, 16'd1);
        frame(1, 0, 1, 0, 0, 0, 0, 16'd1);
        frame(0, 0, 1, 0, 0, 0, 0, 16'd1);
        frame(1, 0, 1, 0, 1, 1, 1, 16'd2);
        pulse_width = 16'd1;
        refractory  = 16'd0;
        for (int i = 0; i < 4; i++) frame(0, 0, 1, 0, 1, 0, 1, 16'd2);
        frame(0, 0, 1, 0, 0, 0, 1, 16'd2);
        frame(0, 0, 1, 0, 0, 0, 1, 16'd2);
        reset_n = 1'b0;
        @(posedge dataclk);
        #1;
        check("rst2_ttl",   {31'd0, event_ttl},    32'd0);
        check("rst2_stb",   {31'd0, event_strobe}, 32'd0);
        check("rst2_busy",  {31'd0, event_busy},   32'd0);
        check("rst2_count", {16'd0, event_count},  32'd0);
`ifdef DAC_EVENT_TIMESTAMP_EN
        exp_ts = 32'd0;
        check("rst2_ts", event_timestamp, exp_ts);
`endif
        reset_n = 1'b1;
        frame(1, 0, 1, 0, 1, 1, 1, 16'd1);
        frame(0, 0, 1, 0, 0, 0, 0, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
